soc_pio_in_capture: RTL and testbench
=====================================

// Module: soc_pio_in_capture
// PURPOSE
//  Avalon-MM slave input PIO. The companion of the SoC output PIO: it samples an external
//  WIDTH-bit input bus through a 2-FF synchroniser and latches per-bit edges into an
//  edge-capture register. It raises a maskable interrupt to the Nios II. It sits on the
//  system interconnect beside the output PIO and is polled or serviced by IRQ in software.
// PARAMETERS
//  WIDTH     8  width of in_port and of every register (1..32)
//  EDGE_TYPE 0  capture edge: 0 rising, 1 falling, 2 any
//  IRQ_TYPE  1  0 level (irq from synced data & mask), 1 edge (irq from edgecapture & mask)
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  address    in   2      register select (word offset)
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe (qualified by chipselect)
//  writedata  in   32     write data; bits above WIDTH-1 ignored
//  in_port    in   WIDTH  asynchronous external inputs
//  readdata   out  32     registered read data, zero-extended above WIDTH
//  irq        out  1      interrupt request, active high
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is synchronous and active-high.
//  Register map:
//    0 DATA       RO  synced input (sync2); writes ignored
//    1 reserved   RO  reads 0; writes ignored
//    2 IRQMASK    RW  per-bit interrupt enable
//    3 EDGECAP    R/W1C  writing 1 to a bit clears that bit
//  Reset (reset=1 at a clk edge):
//    sync1, sync2, prev, IRQMASK, EDGECAP and readdata <= 0; irq = 0; arm counter <= 0.
//  Synchroniser pipeline: sync1 <= in_port; sync2 <= sync1; prev <= sync2, every cycle.
//  Edge detect, combinational from sync2 and prev:
//    rise = sync2 & ~prev; fall = ~sync2 & prev; any = rise | fall. EDGE_TYPE selects one.
//  Arming:
//    - A 2-bit saturating counter increments each cycle after reset until it reaches 3.
//    - Edge detect is forced to 0 while the counter is < 3.
//    - A high in_port during reset therefore never produces a spurious capture.
//  EDGECAP update per bit, each cycle:
//    next = (EDGECAP & ~clr) | edge
//    clr = writedata bit when (chipselect & ~write_n & address==3), else 0.
//    A simultaneous set and clear on the same bit: set wins (bit stays 1).
//  IRQMASK <= writedata[WIDTH-1:0] on (chipselect & ~write_n & address==2).
//  Latency:
//    - in_port sampled at edge k appears in sync2 after edge k+1.
//    - The resulting edge sets EDGECAP at edge k+2.
//  Read:
//    - readdata <= mux(address) at every clk edge while chipselect=1 (read latency 1).
//    - When chipselect=0, readdata <= 0.
//    - Reads have no side effects; reading EDGECAP does not clear it.
//  irq, combinational from registers:
//    IRQ_TYPE=1: |(EDGECAP & IRQMASK)
//    IRQ_TYPE=0: |(sync2 & IRQMASK)
//  Writes and reads to the same address in one cycle:
//    readdata returns the pre-write register value.
//  Reset asserted mid-operation:
//    - All state clears at that edge.
//    - Pending captures are lost and the arm counter restarts.
// TESTING
//  1. Hold in_port=0xFF through reset, release, wait 10 cycles -> EDGECAP reads 0x00, irq=0.
//  2. EDGE_TYPE=0, IRQ_TYPE=1, IRQMASK=0x08; drive in_port bit3 0->1 at edge k.
//     -> EDGECAP=0x08 after edge k+2; irq=1 in the same cycle; DATA reads 0x08.
//  3. With EDGECAP=0x0C, write 0x04 to addr 3 in the same cycle a new bit3 edge arrives.
//     -> EDGECAP=0x08 (bit2 cleared, bit3 held); irq stays 1.
//  4. IRQ_TYPE=0, IRQMASK=0x01; toggle in_port bit0 1,0.
//     -> irq follows sync2[0] with 2-cycle delay; IRQMASK=0 forces irq=0.
//  5. Read addr 0/1/2/3 back-to-back with chipselect=1.
//     -> each readdata value valid one cycle after its address; addr 1 returns 0;
//        chipselect=0 gives readdata=0.
//  6. Assert reset with EDGECAP=0xFF and IRQMASK=0xFF.
//     -> next cycle all read 0, irq=0; edges in the following 2 cycles are ignored.

Source files
------------

// File: rtl/soc_pio_in_capture.sv
// Avalon-MM input PIO: 2-FF synchronised input bus, armed per-bit edge capture
// with write-1-to-clear, interrupt mask and a registered read port.
module soc_pio_in_capture #(
   parameter int WIDTH     = 8,
   parameter int EDGE_TYPE = 0,
   parameter int IRQ_TYPE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] wr_bits;
   logic [1:0]       arm_cnt;
   logic             wr_en;
   logic [31:0]      rd_mux;

   assign wr_en   = chipselect & ~write_n;
   assign wr_bits = writedata[WIDTH-1:0];

   function automatic logic [WIDTH-1:0] select_edge(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] old);
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      rise = cur & ~old;
      fall = ~cur & old;
      if (EDGE_TYPE == 0)
         return rise;
      else if (EDGE_TYPE == 1)
         return fall;
      else
         return rise | fall;
   endfunction

   // Edges are suppressed until the arm counter saturates, so whatever level the
   // pins held during reset flushes through the synchroniser without a capture.
   always_comb begin
      edge_det = (arm_cnt == 2'd3) ? select_edge(sync2, prev) : '0;
      cap_clr  = (wr_en && address == 2'd3) ? wr_bits : '0;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux[WIDTH-1:0] = sync2;
         2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
         2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         arm_cnt  <= 2'd0;
         readdata <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         prev  <= sync2;
         if (arm_cnt != 2'd3)
            arm_cnt <= arm_cnt + 2'd1;
         // A new edge in the same cycle as a clear keeps the bit set.
         edge_cap <= (edge_cap & ~cap_clr) | edge_det;
         if (wr_en && address == 2'd2)
            irq_mask <= wr_bits;
         readdata <= chipselect ? rd_mux : '0;
      end
   end

   if (IRQ_TYPE == 1) begin : g_irq_edge
      assign irq = |(edge_cap & irq_mask);
   end else begin : g_irq_level
      assign irq = |(sync2 & irq_mask);
   end

   if (WIDTH < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
   end

endmodule

// File: tb/tb_soc_pio_in_capture.sv
// Bench for soc_pio_in_capture: three edge/irq flavours on a shared bus, checked
// every cycle against a sample-history model plus directed literal expectations.
module tb_soc_pio_in_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [7:0]  in_port = 8'hFF;
   logic [31:0] rd_r, rd_f, rd_a;
   logic        irq_r, irq_f, irq_a;

   always #5 clk = ~clk;

   soc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_r), .irq(irq_r));

   soc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(0)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_f), .irq(irq_f));

   soc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_a), .irq(irq_a));

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Model: remember every value in_port held at each clock edge. The input seen
   // by software after edge n is the sample from edge n-1; an edge is the change
   // between the samples of edges n-2 and n-3, ignored until 4 edges after reset.
   int          n = 0;
   int          r = 0;
   bit          ok = 1'b0;
   logic [7:0]  hist[int];
   logic [7:0]  m_ec[3];
   logic [7:0]  m_mask;
   logic [31:0] m_rd[3];

   function automatic logic [7:0] samp(input int e);
      if (e <= r || !hist.exists(e))
         return 8'h00;
      return hist[e];
   endfunction

   function automatic logic [7:0] edges(input int t, input logic [7:0] s, input logic [7:0] p);
      if (t == 0) return s & ~p;
      if (t == 1) return ~s & p;
      return s ^ p;
   endfunction

   always @(posedge clk) begin : model
      logic [7:0] data_now;
      logic [7:0] clr;
      logic [7:0] e;
      n++;
      hist[n] = in_port;
      if (reset) begin
         r = n;
         ok = 1'b1;
         m_mask = 8'h00;
         for (int t = 0; t < 3; t++) begin
            m_ec[t] = 8'h00;
            m_rd[t] = 32'd0;
         end
      end else begin
         data_now = samp(n - 2);
         for (int t = 0; t < 3; t++) begin
            if (!chipselect)        m_rd[t] = 32'd0;
            else if (address == 0)  m_rd[t] = {24'd0, data_now};
            else if (address == 2)  m_rd[t] = {24'd0, m_mask};
            else if (address == 3)  m_rd[t] = {24'd0, m_ec[t]};
            else                    m_rd[t] = 32'd0;
         end
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
         for (int t = 0; t < 3; t++) begin
            e = (n >= r + 4) ? edges(t, samp(n - 2), samp(n - 3)) : 8'h00;
            m_ec[t] = (m_ec[t] & ~clr) | e;
         end
         if (chipselect && !write_n && address == 2'd2)
            m_mask = writedata[7:0];
      end
      #2;
      if (ok) begin
         chk("rd_rise", rd_r, m_rd[0]);
         chk("rd_fall", rd_f, m_rd[1]);
         chk("rd_any", rd_a, m_rd[2]);
         chk1("irq_rise", irq_r, |(m_ec[0] & m_mask));
         chk1("irq_fall_level", irq_f, |(samp(n - 1) & m_mask));
         chk1("irq_any", irq_a, |(m_ec[2] & m_mask));
      end
   end

   task automatic idle(input int k);
      @(negedge clk);
      chipselect = 1'b0;
      write_n = 1'b1;
      repeat (k - 1) @(negedge clk);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a;
      writedata = d;
      chipselect = 1'b1;
      write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n = 1'b1;
   endtask

   task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      address = a;
      chipselect = 1'b1;
      write_n = 1'b1;
      @(posedge clk);
      #2;
      chk(name, rd_r, exp);
   endtask

   logic [31:0] exp5[4];

   initial begin
      // Pins high through reset must not be captured once released.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(10);
      read_chk(2'd3, 32'h00, "t1_edgecap");
      chk1("t1_irq", irq_r, 1'b0);
      read_chk(2'd0, 32'hFF, "t1_data");

      // Rising edge on bit 3 with mask 0x08.
      @(negedge clk);
      in_port = 8'h00;
      idle(4);
      do_write(2'd2, 32'h08);
      idle(2);
      @(negedge clk);
      in_port = 8'h08;
      @(posedge clk); #2; chk1("t2_irq_k", irq_r, 1'b0);
      @(posedge clk); #2; chk1("t2_irq_k1", irq_r, 1'b0);
      @(posedge clk); #2; chk1("t2_irq_k2", irq_r, 1'b1);
      read_chk(2'd3, 32'h08, "t2_edgecap");
      read_chk(2'd0, 32'h08, "t2_data");

      // Clear bit 2 while a fresh bit-3 edge lands.
      @(negedge clk);
      in_port = 8'h0C;
      idle(4);
      read_chk(2'd3, 32'h0C, "t3_edgecap_pre");
      @(negedge clk);
      in_port = 8'h04;
      idle(4);
      @(negedge clk);
      in_port = 8'h0C;
      @(negedge clk);
      do_write(2'd3, 32'h04);
      chk1("t3_irq", irq_r, 1'b1);
      read_chk(2'd3, 32'h08, "t3_edgecap");

      // Clearing the very bit that is being set leaves it set.
      @(negedge clk);
      in_port = 8'h04;
      idle(4);
      @(negedge clk);
      in_port = 8'h0C;
      @(negedge clk);
      do_write(2'd3, 32'h08);
      read_chk(2'd3, 32'h08, "t3_set_wins");
      do_write(2'd3, 32'h08);
      read_chk(2'd3, 32'h00, "t3_clear");
      chk1("t3_irq_clear", irq_r, 1'b0);

      // Level interrupt follows the synchronised bit 0.
      do_write(2'd2, 32'h01);
      idle(2);
      @(negedge clk);
      in_port = 8'h0D;
      @(posedge clk); #2; chk1("t4_lvl_k", irq_f, 1'b0);
      @(posedge clk); #2; chk1("t4_lvl_k1", irq_f, 1'b1);
      @(negedge clk);
      in_port = 8'h0C;
      @(posedge clk); #2; chk1("t4_lvl_hold", irq_f, 1'b1);
      @(posedge clk); #2; chk1("t4_lvl_drop", irq_f, 1'b0);
      @(negedge clk);
      in_port = 8'h0D;
      idle(3);
      chk1("t4_lvl_high", irq_f, 1'b1);
      do_write(2'd2, 32'h00);
      chk1("t4_masked", irq_f, 1'b0);

      // Back-to-back reads of the whole map, then deselect.
      do_write(2'd3, 32'hFF);
      do_write(2'd2, 32'h5A);
      exp5[0] = 32'h0D;
      exp5[1] = 32'h00;
      exp5[2] = 32'h5A;
      exp5[3] = 32'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         address = 2'(i);
         chipselect = 1'b1;
         write_n = 1'b1;
         @(posedge clk);
         #2;
         chk($sformatf("t5_read_%0d", i), rd_r, exp5[i]);
      end
      @(negedge clk);
      chipselect = 1'b0;
      @(posedge clk); #2; chk("t5_deselect", rd_r, 32'h00);

      // Reset mid-operation, then edges during re-arming are ignored.
      @(negedge clk);
      in_port = 8'h00;
      idle(4);
      do_write(2'd2, 32'hFF);
      @(negedge clk);
      in_port = 8'hFF;
      idle(4);
      read_chk(2'd3, 32'hFF, "t6_edgecap_pre");
      chk1("t6_irq_pre", irq_r, 1'b1);
      @(negedge clk);
      chipselect = 1'b0;
      reset = 1'b1;
      in_port = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      in_port = 8'hFF;
      chk1("t6_irq_rst", irq_r, 1'b0);
      chk1("t6_irq_any_rst", irq_a, 1'b0);
      chk("t6_rd_rst", rd_r, 32'h00);
      idle(8);
      read_chk(2'd3, 32'h00, "t6_edgecap_post");
      read_chk(2'd2, 32'h00, "t6_mask_post");
      read_chk(2'd0, 32'hFF, "t6_data_post");
      @(negedge clk);
      in_port = 8'h00;
      idle(4);
      do_write(2'd2, 32'h10);
      @(negedge clk);
      in_port = 8'h10;
      idle(4);
      read_chk(2'd3, 32'h10, "t6_rearmed");
      chk1("t6_irq_rearmed", irq_r, 1'b1);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
